// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM encoding and digit helpers for the
// BCD <-> binary converters (double-dabble and reverse double-dabble).
package bcd_pkg;

  localparam int DIGIT_W = 4;

  // reverse double-dabble: subtract 3 from any digit >= 8
  localparam logic [3:0] CORR_THRESH = 4'd8;
  localparam logic [3:0] CORR_SUB    = 4'd3;

  // forward double-dabble (display path): add 3 to any digit >= 5
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL    = 4'd3;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  function automatic logic digit_bad(
    input logic [DIGIT_W-1:0] d
  );
    return d > BCD_MAX_DIGIT;
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_add3(
    input logic [DIGIT_W-1:0] d
  );
    return (d >= ADD3_THRESH) ? d + ADD3_VAL : d;
  endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One BCD digit correction for reverse double-dabble.
// Ports: d_in (4-bit digit after shift), d_out (d_in-3 if d_in>=8).
module bcd_digit_corr
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_in,
  output logic [DIGIT_W-1:0] d_out
);

  // 4-bit subtract; never borrows into the next digit
  always_comb begin
    d_out = d_in;
    if (d_in >= CORR_THRESH)
      d_out = d_in - CORR_SUB;
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential reverse double-dabble: packed BCD -> binary, one shift/cycle.
// Ports: clk, reset (sync, active-high), start, bcd_in[4*DIGITS-1:0]
//   -> busy, done (1-cycle pulse), binary_out[BIN_W-1:0], error, clamped.
// Optional: define BCD_CLAMP_EN to clamp the result to MAX_VAL.
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 2047
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                      busy,
  output logic                      done,
  output logic [BIN_W-1:0]          binary_out,
  output logic                      error,
  output logic                      clamped
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (((10 ** DIGITS) - 1 >= (1 << BIN_W)) ||
      (MAX_VAL >= (1 << BIN_W))) begin : g_bad_cfg
    $error("bcd_to_binary: BIN_W too narrow");
  end

  state_t state_q, state_d;

  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_sh, bcd_corr;
  logic [BIN_W-1:0] bin_q, bin_d, bin_sh;
  logic [BIN_W-1:0] bout_q, bout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             clamp_q, clamp_d;
  logic             in_bad;
  logic             last_shift;

  // {bcd, bin} >> 1: bcd LSB falls into bin MSB
  assign bcd_sh = bcd_q >> 1;
  assign bin_sh = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_digit_corr u_corr (
      .d_in  (bcd_sh[g*DIGIT_W +: DIGIT_W]),
      .d_out (bcd_corr[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      in_bad = in_bad | digit_bad(bcd_in[i*DIGIT_W +: DIGIT_W]);
  end

  assign last_shift = (cnt_q == CNT_W'(1));

  // state register and datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      bout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      clamp_q <= clamp_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start)
          state_d = in_bad ? ST_DONE : ST_CONVERT;
      end
      ST_CONVERT: begin
        if (last_shift)
          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // datapath / output logic; results are registered on the edge
  // entering DONE so they are valid during the DONE cycle
  always_comb begin
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    err_d   = err_q;
    clamp_d = clamp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          bin_d   = '0;
          err_d   = 1'b0;
          clamp_d = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          if (in_bad) begin
            cnt_d  = '0;
            done_d = 1'b1;
            err_d  = 1'b1;
            bout_d = '0;
          end
        end
      end
      ST_CONVERT: begin
        bcd_d = bcd_corr;
        bin_d = bin_sh;
        cnt_d = cnt_q - CNT_W'(1);
        if (last_shift) begin
          done_d = 1'b1;
`ifdef BCD_CLAMP_EN
          if (bin_sh > BIN_W'(MAX_VAL)) begin
            bout_d  = BIN_W'(MAX_VAL);
            clamp_d = 1'b1;
          end else begin
            bout_d  = bin_sh;
            clamp_d = 1'b0;
          end
`else
          bout_d  = bin_sh;
          clamp_d = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  assign busy       = (state_q == ST_CONVERT);
  assign done       = done_q;
  assign binary_out = bout_q;
  assign error      = err_q;
  assign clamped    = clamp_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed cases plus
// randomized conversions against a decimal arithmetic model.
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [13:0] binary_out;
  logic        error;
  logic        clamped;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_conv  = 0;
  logic [13:0] last_bin = '0;

  bcd_to_binary #(
    .DIGITS  (4),
    .BIN_W   (14),
    .MAX_VAL (2047)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bcd_in     (bcd_in),
    .busy       (busy),
    .done       (done),
    .binary_out (binary_out),
    .error      (error),
    .clamped    (clamped)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (done === 1'b1) n_done++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // decimal value of the packed digits; error if any digit > 9
  function automatic void model(input logic [15:0] v,
                                output int b, output bit e,
                                output bit c);
    int d;
    b = 0; e = 0; c = 0;
    for (int i = 0; i < 4; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) e = 1;
      b += d * (10 ** i);
    end
    if (e) b = 0;
`ifdef BCD_CLAMP_EN
    if (b > 2047) begin
      b = 2047;
      c = 1;
    end
`endif
  endfunction

  function automatic logic [15:0] rand_valid();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [15:0] rand_bad();
    logic [15:0] v;
    int p;
    v = rand_valid();
    p = int'($urandom_range(0, 3));
    v[4*p +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  // Starts one conversion in an IDLE cycle; optionally pulses an
  // (ignored) start at cycle ign_k. Also pulses start during DONE.
  task automatic conv(input logic [15:0] v,
                      input int ign_k,
                      input logic [15:0] ign_v);
    int  eb, k, busy_n;
    bit  ee, ec, hold_bad;
    model(v, eb, ee, ec);
    bcd_in = v;
    start  = 1'b1;
    step();
    k = 1; busy_n = 0; hold_bad = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) busy_n++;
      if (binary_out !== last_bin || error !== 1'b0 ||
          clamped !== 1'b0)
        hold_bad = 1;
      if (k == ign_k) begin
        start  = 1'b1;
        bcd_in = ign_v;
      end else begin
        start  = 1'b0;
        bcd_in = 16'($urandom);
      end
      step();
      k++;
    end
    chk("latency", k, ee ? 1 : 15);
    chk("busy_cycles", busy_n, ee ? 0 : 14);
    chk("hold_during_convert", 32'(hold_bad), 0);
    chk("busy_at_done", 32'(busy), 0);
    chk("binary_out", 32'(binary_out), eb);
    chk("error", 32'(error), 32'(ee));
    chk("clamped", 32'(clamped), 32'(ec));
    if (!ee) chk("bcd_residual", 32'(dut.bcd_q), 0);
    start  = 1'b1;
    bcd_in = rand_valid();
    step();
    start  = 1'b0;
    chk("start_in_done_ignored", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
    chk("error_held", 32'(error), 32'(ee));
    chk("out_held", 32'(binary_out), eb);
    n_conv++;
    last_bin = 14'(eb);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out", 32'(binary_out), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_clamped", 32'(clamped), 0);
    reset = 1'b0;
    step();

    conv(16'h0500, 0, '0);
    conv(16'h9999, 0, '0);
    conv(16'h0A12, 0, '0);
    conv(16'h1234, 5, 16'h0042);
    conv(16'h0042, 0, '0);
    conv(16'h0000, 0, '0);
    conv(16'h2047, 0, '0);
    conv(16'h2048, 0, '0);
    conv(16'hFFFF, 0, '0);
    conv(16'h0009, 0, '0);

    // reset in the middle of a conversion
    bcd_in = 16'h0777;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_out", 32'(binary_out), 0);
    chk("midrst_error", 32'(error), 0);
    last_bin = '0;
    conv(16'h0001, 0, '0);

    for (int i = 0; i < 1500; i++)
      conv(rand_valid(), 0, '0);
    for (int i = 0; i < 100; i++)
      conv(rand_bad(), 0, '0);

    step();
    chk("done_count", n_done, n_conv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential reverse double-dabble converter: turns a packed BCD value into binary. It is the inverse of the existing binary-to-BCD display converter.
- Lets the game take decimal settings entered on SW in BCD, for example hit-window threshold or round length. The binary result drives timer compare logic.
- Converts one shift per cycle with a start/busy/done handshake. The same logic is reused for every digit.

Parameters:
- DIGITS, 4, number of packed BCD input digits.
- BIN_W, 14, binary output width; must satisfy 10^DIGITS-1 < 2^BIN_W.
- MAX_VAL, 2047, clamp ceiling; used only when BCD_CLAMP_EN is defined. The default matches the 11-bit timer range.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0]; captured on the accepted start cycle.
- busy  output  1  high while in CONVERT.
- done  output  1  one-cycle pulse when the result is valid.
- binary_out  output  BIN_W  converted value; holds its value until the next done.
- error  output  1  set with done if any captured digit > 9; held until the next accepted start.
- clamped  output  1  set with done if the result was clamped; held like error.

Behaviour:
- Reset (synchronous, active-high, any state including mid-CONVERT):
  - state goes to IDLE.
  - busy, done, error and clamped are 0; binary_out is 0.
  - The shift registers and iteration counter are cleared.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - On start=1, capture bcd_in into the BCD shift register, clear the binary shift register, clear error and clamped.
  - If any digit > 9, go to DONE with the error path.
  - Otherwise go to CONVERT with the counter loaded to BIN_W.
- CONVERT, once per cycle:
  - Shift the concatenation {bcd_reg, bin_reg} right by 1. The bcd_reg LSB enters the bin_reg MSB.
  - Then, for each digit of the shifted bcd_reg: if digit >= 8, subtract 3, applied independently per digit.
  - Decrement the counter. When it reaches 0 after the shift, go to DONE.
  - busy=1 for exactly BIN_W cycles.
- DONE (one cycle):
  - done=1 and binary_out is updated.
  - On the error path: binary_out=0 and error=1.
  - Otherwise: binary_out = bin_reg, with clamping applied if enabled.
  - Unconditionally returns to IDLE.
- Latency:
  - Valid input: done is asserted BIN_W+1 cycles after the start cycle (15 for the defaults).
  - Invalid input: done is asserted 1 cycle after start.
- Handshake:
  - start in CONVERT or DONE is ignored, not queued.
  - Back-to-back start is accepted in the cycle after done.
- Width:
  - Each digit correction is a 4-bit subtract with no borrow into the neighbouring digit.
  - After BIN_W shifts, bcd_reg must be 0 for valid input; this is an assertion in verification.
- bcd_in changing during CONVERT has no effect, because the value is captured at start.

Optional Feature:
- Macro: BCD_CLAMP_EN.
- Defined:
  - At DONE, if bin_reg > MAX_VAL, then binary_out=MAX_VAL and clamped=1.
  - Otherwise binary_out=bin_reg and clamped=0.
  - The compare is registered into the DONE cycle; latency is unchanged.
- Undefined:
  - binary_out = bin_reg with no limit.
  - clamped is tied to 0.
  - MAX_VAL is unused.

Decomposition:
- Shared package bcd_pkg contains:
  - DIGIT_W=4.
  - CORR_THRESH=4'd8 and CORR_SUB=4'd3.
  - BCD_MAX_DIGIT=4'd9.
  - The state encoding for IDLE, CONVERT and DONE.
  - The same constants reused by the binary-to-BCD display converter (add-3 threshold 5).
- One sub-module, bcd_digit_corr: combinational 4-bit in/out, subtracts 3 when the input is >= 8. It is instantiated DIGITS times via a generate loop.

Test Plan:
- bcd_in=16'h0500, start pulse -> busy for 14 cycles; done at start+15; binary_out=500; error=0.
- bcd_in=16'h9999 (clamp disabled) -> binary_out=9999 (14'h270F) at start+15. With BCD_CLAMP_EN -> binary_out=2047, clamped=1.
- bcd_in=16'h0A12 -> done at start+1; error=1; binary_out=0; busy never asserted.
- Start with 16'h1234, then a second start with 16'h0042 at cycle +5 -> the second is ignored; done once with 1234. A start in the cycle after done with 16'h0042 -> binary_out=42.
- Start with 16'h0777, assert reset at cycle +6 for 1 cycle -> next cycle busy=0, done=0, binary_out=0. A fresh start with 16'h0001 -> binary_out=1 at start+15.
- Exhaustive sweep 0000..9999 back-to-back -> binary_out equals the decimal value for every input; done pulse count = 10000.
